add_pipe_counter: RTL and testbench

- Parametrised successor of the team's registered-adder/counter block.
- An elastic adder pipeline: A+B with a full-width carry, STAGES register stages deep, valid/ready handshake on both sides.
- A transfer/step counter with wrap or saturate mode, sync load, and a wrap/saturation flag.
- Used as a throughput-accounting datapath element between streaming producers and consumers.

---
 rtl/add_pipe_pkg.sv | 34 +++
 rtl/add_pipe_counter_stage.sv | 40 ++++
 rtl/add_pipe_counter.sv | 138 +++++++++++++
 tb/tb_add_pipe_counter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// ---------------------------------------------------------------------------
// add_pipe_pkg
// Shared types and helpers for the add_pipe_counter block.
//   cnt_mode_e : counter overflow behaviour (wrap modulo 2^CNT_W or clamp).
//   sat_add    : unsigned add of a counter value and an increment, returning
//                {value, overflow}. The value is the raw (wrapped) sum; the
//                caller decides whether to wrap or clamp using the overflow
//                bit. Counters up to 32 bits wide are supported.
// ---------------------------------------------------------------------------
package add_pipe_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int unsigned SAT_ADD_W = 32;

    // Result layout: [SAT_ADD_W:1] = sum bits, [0] = overflow past width w.
    // Both operands must already fit in w bits; inc is small relative to 2^w,
    // so the sum can exceed the counter range by at most one wrap.
    function automatic logic [SAT_ADD_W:0] sat_add(
        input logic [SAT_ADD_W-1:0] cur,
        input logic [SAT_ADD_W-1:0] inc,
        input int unsigned          w
    );
        logic [SAT_ADD_W:0] total;
        logic               ovf;
        total = {1'b0, cur} + {1'b0, inc};
        ovf   = (total >> w) != '0;
        return {total[SAT_ADD_W-1:0], ovf};
    endfunction

endpackage

// File: rtl/add_pipe_counter_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
// One elastic register slot of the adder pipeline: a valid bit plus a data
// word. The slot may load whenever it is empty or its contents are moving on
// downstream, so empty slots (bubbles) are squeezed out as data flows.
//   clk, rst    : clock and synchronous active-high reset
//   prev_valid  : valid from the upstream slot (or the input port)
//   prev_data   : data from the upstream slot (or the input adder)
//   next_adv    : downstream slot can take this slot's contents
//   adv         : this slot can take new contents this cycle
//   valid, data : registered slot contents
// ---------------------------------------------------------------------------
module pipe_stage
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_adv,
    output logic             adv,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign adv = !valid || next_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (adv) begin
            valid <= prev_valid;
            data  <= prev_data;
        end
    end

endmodule

// File: rtl/add_pipe_counter.sv
// ---------------------------------------------------------------------------
// add_pipe_counter
// Elastic adder pipeline with a throughput/step counter alongside it.
// The adder computes a+b with a full carry bit and passes it through STAGES
// valid/ready register slots; the counter accumulates one per completed
// output transfer plus an optional per-cycle step, wrapping or saturating.
//
// Ports
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   in_valid      : operand pair a/b is valid
//   in_ready      : pipeline can accept an operand pair this cycle
//   a, b          : WIDTH-bit unsigned operands
//   out_valid     : sum is valid
//   out_ready     : consumer accepts the sum this cycle
//   sum           : WIDTH+1-bit result, MSB is the carry
//   cnt_ena       : add cnt_step to the counter this cycle
//   cnt_step      : STEP_W-bit step amount
//   cnt_load      : load cnt_load_val (overrides any increment)
//   cnt_load_val  : CNT_W-bit load value
//   cnt_value     : counter value
//   cnt_flag      : wrap pulse (SATURATE=0) or sticky saturated (SATURATE=1)
// ---------------------------------------------------------------------------
module add_pipe_counter
    import add_pipe_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int CNT_W    = 8,
    parameter int STEP_W   = 4,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    sum,
    input  logic              cnt_ena,
    input  logic [STEP_W-1:0] cnt_step,
    input  logic              cnt_load,
    input  logic [CNT_W-1:0]  cnt_load_val,
    output logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_flag
);

    localparam cnt_mode_e MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam int        LAST  = STAGES - 1;
    localparam int        INC_W = STEP_W + 1;

    // Input adder, zero-extended so the carry is never lost.
    logic [WIDTH:0] sum_in;
    assign sum_in = {1'b0, a} + {1'b0, b};

    logic           vld_p  [STAGES];
    logic [WIDTH:0] data_p [STAGES];
    logic           adv_p  [STAGES];

    // ---- pipeline stages p0 .. p(STAGES-1) ----
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic           prev_vld;
        logic [WIDTH:0] prev_data;
        logic           next_adv;

        if (i == 0) begin : g_head
            assign prev_vld  = in_valid;
            assign prev_data = sum_in;
        end else begin : g_body
            assign prev_vld  = vld_p[i-1];
            assign prev_data = data_p[i-1];
        end

        if (i == LAST) begin : g_tail
            assign next_adv = out_ready;
        end else begin : g_mid
            assign next_adv = adv_p[i+1];
        end

        pipe_stage #(
            .WIDTH (WIDTH + 1)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (prev_vld),
            .prev_data  (prev_data),
            .next_adv   (next_adv),
            .adv        (adv_p[i]),
            .valid      (vld_p[i]),
            .data       (data_p[i])
        );
    end

    // Both handshake outputs are masked during reset so that neither an input
    // nor an output transfer can appear to complete in a reset cycle.
    assign in_ready  = adv_p[0] && !rst;
    assign out_valid = vld_p[LAST] && !rst;
    assign sum       = data_p[LAST];

    // ---- counter ----
    // Output transfer and step are folded into one increment so a coinciding
    // transfer and step land in the same update.
    logic             out_xfer;
    logic [INC_W-1:0] inc;
    logic [SAT_ADD_W:0] add_res;
    logic [CNT_W-1:0] add_val;
    logic             add_ovf;
    logic             unused_add_res;

    assign out_xfer = out_valid && out_ready;
    assign inc      = INC_W'(out_xfer) + (cnt_ena ? INC_W'(cnt_step) : INC_W'(0));
    assign add_res  = sat_add(SAT_ADD_W'(cnt_value), SAT_ADD_W'(inc), CNT_W);
    assign add_val  = add_res[CNT_W:1];
    assign add_ovf  = add_res[0];
    assign unused_add_res = ^add_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_value <= '0;
            cnt_flag  <= 1'b0;
        end else if (cnt_load) begin
            cnt_value <= cnt_load_val;
            cnt_flag  <= 1'b0;
        end else if (MODE == CNT_WRAP) begin
            // Flag is a single-cycle pulse on each wrap.
            cnt_value <= add_val;
            cnt_flag  <= add_ovf;
        end else if (add_ovf) begin
            cnt_value <= '1;
            cnt_flag  <= 1'b1;
        end else begin
            // Saturate mode: flag stays set until reset or load.
            cnt_value <= add_val;
        end
    end

endmodule

// File: tb/tb_add_pipe_counter.sv
module tb_add_pipe_counter;

    localparam int WIDTH   = 8;
    localparam int STAGES  = 2;
    localparam int CNT_W   = 8;
    localparam int STEP_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cnt_ena;
    logic [STEP_W-1:0] cnt_step;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;

    logic              in_ready0, in_ready1;
    logic              out_valid0, out_valid1;
    logic [WIDTH:0]    sum0, sum1;
    logic [CNT_W-1:0]  cnt_value0, cnt_value1;
    logic              cnt_flag0, cnt_flag1;

    add_pipe_counter #(
        .WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W), .STEP_W(STEP_W), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0),
        .cnt_ena(cnt_ena), .cnt_step(cnt_step), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .cnt_value(cnt_value0), .cnt_flag(cnt_flag0)
    );

    add_pipe_counter #(
        .WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W), .STEP_W(STEP_W), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
        .cnt_ena(cnt_ena), .cnt_step(cnt_step), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .cnt_value(cnt_value1), .cnt_flag(cnt_flag1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: items in flight as a queue (oldest first) with the
    // slot index each currently occupies, plus two plain-arithmetic counters.
    int pos_q[$];
    int sum_q[$];
    int cnt_w_m, flag_w_m, cnt_s_m, flag_s_m;
    logic exp_in_ready, exp_out_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int  n, old, old_prev, inc, nx;
        bit  mv, mv_prev, xfer, acc;
        if (rst) begin
            pos_q.delete();
            sum_q.delete();
            cnt_w_m = 0; flag_w_m = 0;
            cnt_s_m = 0; flag_s_m = 0;
            return;
        end
        xfer = exp_out_valid && out_ready;
        acc  = in_valid && exp_in_ready;
        // An item advances if the slot ahead is free or being vacated; the
        // oldest item leaves from the last slot when the consumer accepts.
        n = pos_q.size();
        old_prev = 0; mv_prev = 1'b0;
        for (int i = 0; i < n; i++) begin
            old = pos_q[i];
            if (i == 0) mv = (old < STAGES - 1) || out_ready;
            else        mv = (old_prev != old + 1) || mv_prev;
            old_prev = old;
            mv_prev  = mv;
            if (mv) pos_q[i] = old + 1;
        end
        if (n > 0 && pos_q[0] == STAGES) begin
            void'(pos_q.pop_front());
            void'(sum_q.pop_front());
        end
        if (acc) begin
            pos_q.push_back(0);
            sum_q.push_back(int'(a) + int'(b));
        end
        inc = (xfer ? 1 : 0) + (cnt_ena ? int'(cnt_step) : 0);
        if (cnt_load) begin
            cnt_w_m = int'(cnt_load_val); flag_w_m = 0;
            cnt_s_m = int'(cnt_load_val); flag_s_m = 0;
        end else begin
            nx = cnt_w_m + inc;
            cnt_w_m  = nx % (CNT_MAX + 1);
            flag_w_m = (nx > CNT_MAX) ? 1 : 0;
            nx = cnt_s_m + inc;
            if (nx > CNT_MAX) begin
                cnt_s_m  = CNT_MAX;
                flag_s_m = 1;
            end else begin
                cnt_s_m = nx;
            end
        end
    endtask

    // One clock: compare all outputs mid-cycle against the model, then let
    // the edge happen and advance the model with the same inputs.
    task automatic step();
        @(negedge clk);
        exp_in_ready  = !rst && (out_ready || pos_q.size() < STAGES);
        exp_out_valid = !rst && pos_q.size() > 0 && pos_q[0] == STAGES - 1;
        chk("in_ready_w",  64'(in_ready0),  64'(exp_in_ready));
        chk("in_ready_s",  64'(in_ready1),  64'(exp_in_ready));
        chk("out_valid_w", 64'(out_valid0), 64'(exp_out_valid));
        chk("out_valid_s", 64'(out_valid1), 64'(exp_out_valid));
        if (exp_out_valid) begin
            chk("sum_w", 64'(sum0), 64'(sum_q[0]));
            chk("sum_s", 64'(sum1), 64'(sum_q[0]));
        end
        chk("cnt_w",  64'(cnt_value0), 64'(cnt_w_m));
        chk("flag_w", 64'(cnt_flag0),  64'(flag_w_m));
        chk("cnt_s",  64'(cnt_value1), 64'(cnt_s_m));
        chk("flag_s", 64'(cnt_flag1),  64'(flag_s_m));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; cnt_ena = 1'b0; cnt_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        cnt_ena = 1'b0; cnt_step = '0; cnt_load = 1'b0; cnt_load_val = '0;
        cnt_w_m = 0; flag_w_m = 0; cnt_s_m = 0; flag_s_m = 0;

        // Reset
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_sum",       64'(sum0),       64'd0);
        chk("rst_cnt",       64'(cnt_value0), 64'd0);
        chk("rst_flag",      64'(cnt_flag0),  64'd0);

        // Stream: 200+100 then 255+255
        in_valid = 1'b1; a = 8'd200; b = 8'd100;
        step();
        a = 8'd255; b = 8'd255;
        step();
        in_valid = 1'b0;
        chk("stream_v1",   64'(out_valid0), 64'd1);
        chk("stream_300",  64'(sum0),       64'd300);
        step();
        chk("stream_v2",   64'(out_valid0), 64'd1);
        chk("stream_510",  64'(sum0),       64'd510);
        step();
        step();

        // Backpressure: out_ready low for 5 cycles while offering items
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = WIDTH'(i + 1); b = WIDTH'(10 * i);
            step();
        end
        chk("bp_in_ready", 64'(in_ready0),  64'd0);
        chk("bp_hold_v",   64'(out_valid0), 64'd1);
        chk("bp_hold_sum", 64'(sum0),       64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Counter combine: load 10, then transfer + step 2 together -> 13
        cnt_load = 1'b1; cnt_load_val = 8'd10;
        in_valid = 1'b1; a = 8'd1; b = 8'd2;
        step();
        cnt_load = 1'b0; in_valid = 1'b0;
        step();
        cnt_ena = 1'b1; cnt_step = 4'd2;
        step();
        cnt_ena = 1'b0;
        chk("combine_13", 64'(cnt_value0), 64'd13);

        // Wrap: 254 + 3 -> 1 with a one-cycle flag
        cnt_load = 1'b1; cnt_load_val = 8'd254;
        step();
        cnt_load = 1'b0; cnt_ena = 1'b1; cnt_step = 4'd3;
        step();
        chk("wrap_val",   64'(cnt_value0), 64'd1);
        chk("wrap_flag",  64'(cnt_flag0),  64'd1);
        cnt_ena = 1'b0;
        step();
        chk("wrap_pulse", 64'(cnt_flag0),  64'd0);

        // Saturate: 250 + 15 -> 255 sticky; load 7 with ena clears
        cnt_load = 1'b1; cnt_load_val = 8'd250;
        step();
        cnt_load = 1'b0; cnt_ena = 1'b1; cnt_step = 4'd15;
        step();
        chk("sat_val",   64'(cnt_value1), 64'd255);
        chk("sat_flag",  64'(cnt_flag1),  64'd1);
        step();
        chk("sat_hold",  64'(cnt_value1), 64'd255);
        chk("sat_stick", 64'(cnt_flag1),  64'd1);
        cnt_load = 1'b1; cnt_load_val = 8'd7;
        step();
        idle();
        chk("sat_load_val",  64'(cnt_value1), 64'd7);
        chk("sat_load_flag", 64'(cnt_flag1),  64'd0);

        // Mid-stream reset with two items in flight
        in_valid = 1'b1; a = 8'd9; b = 8'd9;
        step();
        a = 8'd17;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", 64'(out_valid0), 64'd0);
        chk("mrst_cnt",   64'(cnt_value0), 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("mrst_stale", 64'(out_valid0), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            in_valid     = 1'($urandom_range(0, 1));
            out_ready    = ($urandom_range(0, 3) != 0);
            a            = WIDTH'($urandom);
            b            = WIDTH'($urandom);
            cnt_ena      = 1'($urandom_range(0, 1));
            cnt_step     = STEP_W'($urandom);
            cnt_load     = ($urandom_range(0, 31) == 0);
            cnt_load_val = CNT_W'($urandom);
            step();
        end

        // Drain
        rst = 1'b0; idle(); out_ready = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) step();
        chk("drain_empty", 64'(out_valid0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
